// File: rtl/synth_pkg.sv
// Shared sizing, note type and steal-pointer helper for the voice allocator.
package synth_pkg;

  localparam int unsigned NUM_VOICES = 4;
  localparam int unsigned NUM_KEYS   = 16;
  localparam int unsigned NOTE_W     = $clog2(NUM_KEYS);

  typedef logic [NOTE_W-1:0] note_t;

  // Round-robin successor of ptr in the range 0..n-1.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder: valid when any bit is set, index of the lowest one.
module lsb_prio_enc #(
  parameter int unsigned Width = 16,
  parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] req_i,
  output logic             valid_o,
  output logic [IdxW-1:0]  idx_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps held keys onto a fixed pool of oscillator voices,
// one allocation per cycle, lowest pending key to lowest free voice.
// Optional feature macro: VOICE_STEAL_EN -- when no voice is free, the pending key takes
// voice rr_ptr (round robin) and steal_o pulses; otherwise the key waits for a free voice.
module voice_alloc #(
  parameter int unsigned NUM_VOICES = synth_pkg::NUM_VOICES,
  parameter int unsigned NUM_KEYS   = synth_pkg::NUM_KEYS,
  parameter int unsigned NoteW      = $clog2(NUM_KEYS)
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [NUM_KEYS-1:0]         keys_i,
  output logic [NUM_VOICES-1:0]       voice_active_o,
  output logic [NUM_VOICES*NoteW-1:0] voice_note_o,
  output logic [NUM_VOICES-1:0]       voice_gate_o,
  output logic                        steal_o
);

  import synth_pkg::*;

  localparam int unsigned VIdxW = $clog2(NUM_VOICES);

  logic [NUM_KEYS-1:0]   served_q, served_d;
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [NoteW-1:0]      note_q [NUM_VOICES];
  logic [NoteW-1:0]      note_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q, gate_d;

  logic [NUM_KEYS-1:0] pending, released;
  logic                pend_vld, free_vld;
  logic [NoteW-1:0]    pend_idx;
  logic [VIdxW-1:0]    free_idx;
  logic                alloc_en;
  logic [VIdxW-1:0]    alloc_v;

  assign pending  = keys_i & ~served_q;
  assign released = ~keys_i & served_q;

  lsb_prio_enc #(
    .Width (NUM_KEYS),
    .IdxW  (NoteW)
  ) u_pend_enc (
    .req_i   (pending),
    .valid_o (pend_vld),
    .idx_o   (pend_idx)
  );

  // Free set is taken at cycle start, so voices released this cycle are not reused yet.
  lsb_prio_enc #(
    .Width (NUM_VOICES),
    .IdxW  (VIdxW)
  ) u_free_enc (
    .req_i   (~active_q),
    .valid_o (free_vld),
    .idx_o   (free_idx)
  );

`ifdef VOICE_STEAL_EN
  logic [VIdxW-1:0] rr_q, rr_d;
  logic             steal_q, steal_d;
`endif

  // Next state: parallel releases first, then at most one allocation on top.
  always_comb begin
    served_d = served_q & ~released;
    active_d = active_q;
    note_d   = note_q;
    gate_d   = '0;
    alloc_en = 1'b0;
    alloc_v  = '0;
`ifdef VOICE_STEAL_EN
    rr_d     = rr_q;
    steal_d  = 1'b0;
`endif

    // A voice whose key was stolen now holds a different note, so it is unaffected here.
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (active_q[v] && released[note_q[v]]) begin
        active_d[v] = 1'b0;
      end
    end

    if (pend_vld) begin
      if (free_vld) begin
        alloc_en = 1'b1;
        alloc_v  = free_idx;
      end
`ifdef VOICE_STEAL_EN
      else begin
        alloc_en = 1'b1;
        alloc_v  = rr_q;
        rr_d     = VIdxW'(rr_next(int'(rr_q), NUM_VOICES));
        steal_d  = 1'b1;
      end
`endif
    end

    if (alloc_en) begin
      served_d[pend_idx] = 1'b1;
      active_d[alloc_v]  = 1'b1;
      note_d[alloc_v]    = pend_idx;
      gate_d[alloc_v]    = 1'b1;
    end
  end

  // Allocator state registers with asynchronous clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      served_q <= '0;
      active_q <= '0;
      gate_q   <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
      end
    end else begin
      served_q <= served_d;
      active_q <= active_d;
      gate_q   <= gate_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= note_d[v];
      end
    end
  end

`ifdef VOICE_STEAL_EN
  // Steal pointer and steal pulse; the pointer moves only when a steal happens.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_q    <= '0;
      steal_q <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      steal_q <= steal_d;
    end
  end

  assign steal_o = steal_q;
`else
  assign steal_o = 1'b0;
`endif

  assign voice_active_o = active_q;
  assign voice_gate_o   = gate_q;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_note_pack
    assign voice_note_o[v*NoteW +: NoteW] = note_q[v];
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc (4 voices, 16 keys); covers both VOICE_STEAL_EN builds.
module tb_voice_alloc;

  logic        clk;
  logic        nrst;
  logic [15:0] keys;
  logic [3:0]  voice_active;
  logic [15:0] voice_note;
  logic [3:0]  voice_gate;
  logic        steal;

  int total;
  int bad;

  voice_alloc dut (
    .clk            (clk),
    .nrst           (nrst),
    .keys_i         (keys),
    .voice_active_o (voice_active),
    .voice_note_o   (voice_note),
    .voice_gate_o   (voice_gate),
    .steal_o        (steal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] act, input logic [15:0] note,
                         input logic [3:0] gate, input logic stl);
    chk({tag, ".active"}, 32'(voice_active), 32'(act));
    chk({tag, ".note"},   32'(voice_note),   32'(note));
    chk({tag, ".gate"},   32'(voice_gate),   32'(gate));
    chk({tag, ".steal"},  32'(steal),        32'(stl));
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    keys  = '0;
    nrst  = 1'b1;
    #2 nrst = 1'b0;
    #1;
    chk_all("rst0", 4'h0, 16'h0000, 4'h0, 1'b0);
    step();
    step();
    chk_all("rst1", 4'h0, 16'h0000, 4'h0, 1'b0);
    nrst = 1'b1;

    // Single key in and out.
    keys = 16'h0001;
    step();
    chk_all("k0_on", 4'b0001, 16'h0000, 4'b0001, 1'b0);
    step();
    chk_all("k0_hold", 4'b0001, 16'h0000, 4'b0000, 1'b0);
    keys = 16'h0000;
    step();
    chk_all("k0_off", 4'b0000, 16'h0000, 4'b0000, 1'b0);

    // Simultaneous press of keys 0,1,4: one allocation per edge, ascending.
    keys = 16'h0013;
    step();
    chk_all("m1", 4'b0001, 16'h0000, 4'b0001, 1'b0);
    step();
    chk_all("m2", 4'b0011, 16'h0010, 4'b0010, 1'b0);
    step();
    chk_all("m3", 4'b0111, 16'h0410, 4'b0100, 1'b0);
    step();
    chk_all("m4", 4'b0111, 16'h0410, 4'b0000, 1'b0);
    keys = 16'h0000;
    step();
    chk_all("m_off_keepnote", 4'b0000, 16'h0410, 4'b0000, 1'b0);

    // Fill all voices with keys 0..3.
    keys = 16'h000F;
    step();
    step();
    step();
    step();
    chk_all("full", 4'b1111, 16'h3210, 4'b1000, 1'b0);
    step();
    chk_all("full_q", 4'b1111, 16'h3210, 4'b0000, 1'b0);

    // Key 5 with every voice busy.
    keys = 16'h002F;
    step();
`ifdef VOICE_STEAL_EN
    chk_all("st_k5", 4'b1111, 16'h3215, 4'b0001, 1'b1);
    keys = 16'h002E;
    step();
    chk_all("st_rel0", 4'b1111, 16'h3215, 4'b0000, 1'b0);
    keys = 16'h006E;
    step();
    chk_all("st_k6", 4'b1111, 16'h3265, 4'b0010, 1'b1);
`else
    chk_all("ns_k5", 4'b1111, 16'h3210, 4'b0000, 1'b0);
    step();
    chk_all("ns_k5_wait", 4'b1111, 16'h3210, 4'b0000, 1'b0);
    keys = 16'h002B;
    step();
    chk_all("ns_rel2", 4'b1011, 16'h3210, 4'b0000, 1'b0);
    step();
    chk_all("ns_k5_v2", 4'b1111, 16'h3510, 4'b0100, 1'b0);
`endif
    keys = 16'h0000;
    step();
    chk("clr1.active", 32'(voice_active), 32'h0);
    step();

    // Release key 1 and press key 7 in the same cycle, all voices busy.
    keys = 16'h000F;
    step();
    step();
    step();
    step();
    step();
    chk_all("full2", 4'b1111, 16'h3210, 4'b0000, 1'b0);
    keys = 16'h008D;
    step();
`ifdef VOICE_STEAL_EN
    // Two earlier steals leave the pointer at voice 2.
    chk_all("st_swap", 4'b1101, 16'h3710, 4'b0100, 1'b1);
`else
    chk_all("ns_swap1", 4'b1101, 16'h3210, 4'b0000, 1'b0);
    step();
    chk_all("ns_swap2", 4'b1111, 16'h3270, 4'b0010, 1'b0);
`endif
    keys = 16'h0000;
    step();
    chk("clr2.active", 32'(voice_active), 32'h0);
    step();

    // Reset mid-allocation: three voices active, key 3 still pending.
    keys = 16'h000F;
    step();
    step();
    step();
    chk("pre_rst.active", 32'(voice_active), 32'h7);
    nrst = 1'b0;
    #1;
    chk_all("async_rst", 4'h0, 16'h0000, 4'h0, 1'b0);
    step();
    chk_all("rst_hold", 4'h0, 16'h0000, 4'h0, 1'b0);
    nrst = 1'b1;
    step();
    chk_all("realloc1", 4'b0001, 16'h0000, 4'b0001, 1'b0);
    step();
    step();
    step();
    chk_all("realloc4", 4'b1111, 16'h3210, 4'b1000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of oscillator voices managed (2..8).
REQ-002 Parameter NUM_KEYS, default 16, number of keyboard key inputs (power of 2, max 16).
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 nrst  input  1  asynchronous, active-low reset.
REQ-005 keys  input  NUM_KEYS  debounced, synchronous key levels, 1 = held.
REQ-006 voice_active  output  NUM_VOICES  voice v is sounding a note.
REQ-007 voice_note  output  NUM_VOICES*log2(NUM_KEYS)  key index held by voice v, packed with voice 0 in the LSBs.
REQ-008 voice_gate  output  NUM_VOICES  one-cycle pulse when voice v receives a new note (envelope retrigger).
REQ-009 steal  output  1  one-cycle pulse when an allocation took an active voice.

Function
REQ-010 Internal state SHALL be: served[NUM_KEYS], per-voice active and note, and steal pointer rr_ptr.
REQ-011 Pending keys SHALL be keys & ~served; released keys SHALL be ~keys & served.
REQ-012 Every released key j SHALL clear served[j] at the next edge; any voice with active=1 and note=j SHALL clear active at the same edge, and all releases SHALL be handled in parallel.
REQ-013 At most one allocation SHALL occur per cycle, targeting the lowest-index pending key.
REQ-014 Allocation SHALL use the lowest-index voice whose active=0 at cycle start; a voice freed by a release in the same cycle SHALL NOT be reused until the next cycle.
REQ-015 Allocation of key k to voice v SHALL, at the next edge: set served[k]=1, active[v]=1, note[v]=k, and pulse voice_gate[v] for exactly one cycle.
REQ-016 Latency from a key rising to voice_active SHALL be 1 cycle when uncontended; each additional simultaneous press adds 1 cycle in ascending index order.
REQ-017 When every voice is busy (see REQ-022/023), the voice selection of REQ-014 SHALL be replaced by the steal policy; rr_ptr SHALL change only on a steal.
REQ-018 The key that lost its voice SHALL stay served; its later release SHALL clear served only, with no effect on any voice.
REQ-019 A key released before it is allocated SHALL produce no output activity.
REQ-020 voice_note of an inactive voice SHALL retain its last value.

Reset
REQ-021 While nrst=0: served=0, voice_active=0, voice_note=0, voice_gate=0, steal=0, rr_ptr=0, independent of clk; an in-progress allocation SHALL be discarded, and held keys SHALL re-allocate from the first edge after release of reset.

Configuration
REQ-022 With VOICE_STEAL_EN defined, and no voice free: the pending key SHALL take voice rr_ptr, rr_ptr SHALL advance by one modulo NUM_VOICES, and steal SHALL pulse.
REQ-023 Without VOICE_STEAL_EN, and no voice free: the pending key SHALL stay pending and be allocated when a voice frees; steal SHALL be tied to 0.

Structure
REQ-024 Package synth_pkg SHALL hold NUM_VOICES, NUM_KEYS, NOTE_W = log2(NUM_KEYS), and typedef note_t = logic [NOTE_W-1:0].
REQ-025 One sub-module, lsb_prio_enc (parameterised width; outputs valid + index of the lowest set bit), SHALL be instantiated twice: once for pending keys, once for free voices.

Verification
REQ-026 Reset, then keys=0x0001 -> next cycle voice_active=0001, note0=0, voice_gate=0001 for one cycle; keys=0 -> next cycle voice_active=0000.
REQ-027 keys 0x0013 set in one cycle -> keys 0,1,4 land in voices 0,1,2 on three consecutive edges, each with a single voice_gate pulse.
REQ-028 VOICE_STEAL_EN, keys 0..3 held, then key 5 pressed -> voice 0 takes note 5, steal pulses, rr_ptr=1; release key 0 -> no voice change; press key 6 -> voice 1 taken.
REQ-029 No VOICE_STEAL_EN, keys 0..3 held, key 5 pressed -> no change, steal=0; release key 2 -> voice 2 inactive; next cycle voice 2 gets note 5.
REQ-030 Same cycle: release key 1 (voice 1) and press key 7, with all other voices busy -> voice 1 off; with VOICE_STEAL_EN, key 7 takes voice rr_ptr; without it, key 7 takes voice 1 the following cycle.
REQ-031 Assert nrst while 3 voices are active and a press is pending -> all outputs 0 immediately; held keys re-allocate after reset deassertion.
